// File: rtl/rede_io_host_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rede_io_host_if
// Bundles the core-side port protocol (req_in/io_in/out_en/io_out), the
// per-port input and output streams, and the status flags of rede_io_host.
//   master : system/core side (drives requests, stream inputs, m_ready)
//   slave  : rede_io_host itself
// Revision: 1.0
// ---------------------------------------------------------------------------
interface rede_io_host_if #(
  parameter int NUBITS = 31,
  parameter int NUIO   = 4
);
  logic [NUIO-1:0]        req_in;
  logic [NUBITS-1:0]      io_in;
  logic [NUIO-1:0]        out_en;
  logic [NUBITS-1:0]      io_out;
  logic [NUIO*NUBITS-1:0] s_data;
  logic [NUIO-1:0]        s_valid;
  logic [NUIO-1:0]        s_ready;
  logic [NUIO*NUBITS-1:0] m_data;
  logic [NUIO-1:0]        m_valid;
  logic [NUIO-1:0]        m_ready;
  logic [NUIO-1:0]        underflow;
  logic [NUIO-1:0]        overflow;
  logic                   stat_clr;

  modport master (
    output req_in, out_en, io_out, s_data, s_valid, m_ready, stat_clr,
    input  io_in, s_ready, m_data, m_valid, underflow, overflow
  );

  modport slave (
    input  req_in, out_en, io_out, s_data, s_valid, m_ready, stat_clr,
    output io_in, s_ready, m_data, m_valid, underflow, overflow
  );
endinterface
`default_nettype wire

// File: rtl/rede_io_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rede_io_host
// Host-side I/O adapter for the proc_fx core. Core reads (one-hot req_in)
// are served from per-port input FIFOs; core writes (one-hot out_en) land in
// per-port output registers exposed as valid/ready streams.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : rede_io_host_if.slave (core protocol, streams, status flags)
// Optional feature macro: REDE_IO_STATUS_EN enables the sticky
// underflow/overflow flags and stat_clr; otherwise flags read 0.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rede_io_host #(
  parameter int NUBITS = 31,
  parameter int NUIO   = 4,
  parameter int DEPTH  = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  rede_io_host_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [NUBITS-1:0] mem    [NUIO][DEPTH];
  logic [PW-1:0]     rd_ptr [NUIO];
  logic [PW-1:0]     wr_ptr [NUIO];
  logic [CW-1:0]     count  [NUIO];
  logic [NUBITS-1:0] m_word [NUIO];
  logic [NUIO-1:0]   m_valid;
  logic [NUIO-1:0]   empty, full, s_ready, push, pop;
  logic [NUIO-1:0]   rd_oh, ld_oh;
  logic [NUBITS-1:0] io_in;

  // Illegal multi-hot strobes are reduced to their lowest set bit.
  assign rd_oh = bus.req_in & (~bus.req_in + NUIO'(1));
  assign ld_oh = bus.out_en & (~bus.out_en + NUIO'(1));

  generate
    for (genvar k = 0; k < NUIO; k++) begin : g_port
      assign empty[k]   = (count[k] == '0);
      assign full[k]    = (count[k] == CW'(DEPTH));
      // Held low while in reset; a same-cycle pop never opens a full FIFO.
      assign s_ready[k] = rst & ~full[k];
      assign push[k]    = bus.s_valid[k] & s_ready[k];
      assign pop[k]     = rd_oh[k] & ~empty[k];
      assign bus.m_data[k*NUBITS +: NUBITS] = m_word[k];
    end
  endgenerate

  // pop is at most one-hot, so this mux needs no priority.
  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIO; k++) begin
      if (pop[k]) io_in = mem[k][rd_ptr[k]];
    end
  end

  // FIFO storage carries no reset; occupancy alone decides visibility.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUIO; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= bus.s_data[k*NUBITS +: NUBITS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUIO; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUIO; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
        if (push[k] && !pop[k])      count[k] <= count[k] + CW'(1);
        else if (pop[k] && !push[k]) count[k] <= count[k] - CW'(1);
      end
    end
  end

  // A load wins over a handshake in the same cycle, keeping m_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= '0;
      for (int k = 0; k < NUIO; k++) m_word[k] <= '0;
    end else begin
      for (int k = 0; k < NUIO; k++) begin
        if (ld_oh[k]) begin
          m_word[k]  <= bus.io_out;
          m_valid[k] <= 1'b1;
        end else if (bus.m_ready[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.io_in   = io_in;
  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;

`ifdef REDE_IO_STATUS_EN
  logic [NUIO-1:0] udf_q, ovf_q;

  // Clear first, then OR in new events so a same-cycle event survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      udf_q <= '0;
      ovf_q <= '0;
    end else begin
      udf_q <= (bus.stat_clr ? '0 : udf_q) | (rd_oh & empty);
      ovf_q <= (bus.stat_clr ? '0 : ovf_q) | (ld_oh & m_valid & ~bus.m_ready);
    end
  end

  assign bus.underflow = udf_q;
  assign bus.overflow  = ovf_q;
`else
  logic unused_status;
  assign unused_status = bus.stat_clr;
  assign bus.underflow = '0;
  assign bus.overflow  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rede_io_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rede_io_host
// Directed scenarios followed by randomized traffic, each cycle compared
// against a queue-based reference model of the adapter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rede_io_host;
  localparam int NB = 31;
  localparam int NI = 4;
  localparam int DP = 2;
`ifdef REDE_IO_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]    req  = '0;
  logic [NI-1:0]    oe   = '0;
  logic [NI-1:0]    sv   = '0;
  logic [NI-1:0]    mr   = '0;
  logic             clr  = 1'b0;
  logic [NB-1:0]    iout = '0;
  logic [NI*NB-1:0] sd   = '0;

  rede_io_host_if #(.NUBITS(NB), .NUIO(NI)) bus ();

  assign bus.req_in   = req;
  assign bus.out_en   = oe;
  assign bus.s_valid  = sv;
  assign bus.m_ready  = mr;
  assign bus.stat_clr = clr;
  assign bus.io_out   = iout;
  assign bus.s_data   = sd;

  rede_io_host #(.NUBITS(NB), .NUIO(NI), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [NB-1:0] mq [NI][$];
  logic [NB-1:0] m_d [NI];
  logic [NI-1:0] m_v, udf, ovf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      m_d[k] = '0;
    end
    m_v = '0;
    udf = '0;
    ovf = '0;
  endtask

  task automatic check_outputs();
    logic [NB-1:0]    e_io;
    logic [NI-1:0]    e_rdy;
    logic [NI*NB-1:0] e_md;
    e_io = '0;
    for (int k = 0; k < NI; k++) begin
      if (req[k]) begin
        if (mq[k].size() > 0) e_io = mq[k][0];
        break;
      end
    end
    for (int k = 0; k < NI; k++) begin
      e_rdy[k] = (mq[k].size() < DP);
      e_md[k*NB +: NB] = m_d[k];
    end
    check("io_in",     bus.io_in,     e_io);
    check("s_ready",   bus.s_ready,   e_rdy);
    check("m_valid",   bus.m_valid,   m_v);
    check("m_data",    bus.m_data,    e_md);
    check("underflow", bus.underflow, udf);
    check("overflow",  bus.overflow,  ovf);
  endtask

  // Advance the model across the coming clock edge using current inputs.
  task automatic model_step();
    logic [NI-1:0] rdy, ev_u, ev_o;
    int j;
    ev_u = '0;
    ev_o = '0;
    for (int k = 0; k < NI; k++) rdy[k] = (mq[k].size() < DP);
    j = -1;
    for (int k = 0; k < NI; k++) if (req[k]) begin j = k; break; end
    if (j >= 0) begin
      if (mq[j].size() > 0) void'(mq[j].pop_front());
      else ev_u[j] = 1'b1;
    end
    for (int k = 0; k < NI; k++)
      if (sv[k] && rdy[k]) mq[k].push_back(sd[k*NB +: NB]);
    j = -1;
    for (int k = 0; k < NI; k++) if (oe[k]) begin j = k; break; end
    for (int k = 0; k < NI; k++) begin
      if (k == j) begin
        if (m_v[k] && !mr[k]) ev_o[k] = 1'b1;
        m_d[k] = iout;
        m_v[k] = 1'b1;
      end else if (m_v[k] && mr[k]) begin
        m_v[k] = 1'b0;
      end
    end
    if (STATUS) begin
      if (clr) begin
        udf = '0;
        ovf = '0;
      end
      udf |= ev_u;
      ovf |= ev_o;
    end
  endtask

  task automatic cycle(input logic [NI-1:0] a_req, input logic [NI-1:0] a_oe,
                       input logic [NI-1:0] a_sv, input logic [NI-1:0] a_mr,
                       input logic a_clr, input logic [NB-1:0] a_io,
                       input logic [NI*NB-1:0] a_sd);
    @(posedge clk);
    #1;
    req = a_req; oe = a_oe; sv = a_sv; mr = a_mr;
    clr = a_clr; iout = a_io; sd = a_sd;
    #1;
    check_outputs();
    model_step();
  endtask

  function automatic logic [NI-1:0] pick_strobe();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return '0;
    if (r < 9) return NI'(1) << $urandom_range(0, NI-1);
    return NI'($urandom);
  endfunction

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0]    w0, w1, w2, m5;
    logic [NI*NB-1:0] d;
    model_reset();

    // Reset state, with a read request pending to exercise io_in gating
    req = 4'b0001;
    #2;
    check("rst_s_ready", bus.s_ready, '0);
    check("rst_io_in",   bus.io_in,   '0);
    check("rst_m_valid", bus.m_valid, '0);
    check("rst_m_data",  bus.m_data,  '0);
    check("rst_flags",   {bus.underflow, bus.overflow}, '0);
    req = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("post_rst_s_ready", bus.s_ready, 4'hF);

    // Push 0x123 on port 2 then read it back
    d = '0;
    d[2*NB +: NB] = 31'h123;
    cycle('0, '0, 4'b0100, '0, 1'b0, '0, d);
    cycle(4'b0100, '0, '0, '0, 1'b0, '0, '0);
    check("tp1_io_in", bus.io_in, 31'h123);
    cycle('0, '0, '0, '0, 1'b0, '0, '0);
    check("tp1_udf", bus.underflow, '0);

    // Fill port 0 past its depth, then drain in order
    w0 = NB'($urandom); w1 = NB'($urandom); w2 = NB'($urandom);
    cycle('0, '0, 4'b0001, '0, 1'b0, '0, {93'd0, w0});
    cycle('0, '0, 4'b0001, '0, 1'b0, '0, {93'd0, w1});
    cycle('0, '0, 4'b0001, '0, 1'b0, '0, {93'd0, w2});
    check("tp2_full", bus.s_ready[0], 1'b0);
    cycle(4'b0001, '0, 4'b0001, '0, 1'b0, '0, {93'd0, w2});
    check("tp2_rd0", bus.io_in, w0);
    check("tp2_full_pop", bus.s_ready[0], 1'b0);
    cycle(4'b0001, '0, 4'b0001, '0, 1'b0, '0, {93'd0, w2});
    check("tp2_rd1", bus.io_in, w1);
    check("tp2_ready", bus.s_ready[0], 1'b1);
    cycle(4'b0001, '0, '0, '0, 1'b0, '0, '0);
    check("tp2_rd2", bus.io_in, w2);

    // Empty read on port 1, then clear
    cycle(4'b0010, '0, '0, '0, 1'b0, '0, '0);
    check("tp3_io_in", bus.io_in, '0);
    cycle('0, '0, '0, '0, 1'b0, '0, '0);
    check("tp3_udf", bus.underflow, STATUS ? 4'b0010 : 4'b0000);
    cycle('0, '0, '0, '0, 1'b1, '0, '0);
    cycle('0, '0, '0, '0, 1'b0, '0, '0);
    check("tp3_clr", bus.underflow, '0);

    // Output port 3 with a negative word
    m5 = -31'sd5;
    cycle('0, 4'b1000, '0, '0, 1'b0, m5, '0);
    cycle('0, '0, '0, 4'b1000, 1'b0, '0, '0);
    check("tp4_valid", bus.m_valid[3], 1'b1);
    check("tp4_data", bus.m_data[3*NB +: NB], m5);
    cycle('0, '0, '0, '0, 1'b0, '0, '0);
    check("tp4_drain", bus.m_valid[3], 1'b0);

    // Overwrite on port 0 while stalled
    cycle('0, 4'b0001, '0, '0, 1'b0, 31'd7, '0);
    cycle('0, 4'b0001, '0, '0, 1'b0, 31'd9, '0);
    cycle('0, '0, '0, '0, 1'b0, '0, '0);
    check("tp5_data", bus.m_data[NB-1:0], 31'd9);
    check("tp5_ovf", bus.overflow[0], STATUS);
    cycle('0, '0, '0, 4'b0001, 1'b1, '0, '0);

    // Load every port, then reset asynchronously mid-cycle
    cycle('0, 4'b0001, 4'b1111, '0, 1'b0, 31'd1,
          {NB'($urandom), NB'($urandom), NB'($urandom), NB'($urandom)});
    cycle('0, 4'b0010, '0, '0, 1'b0, 31'd2, '0);
    cycle('0, 4'b0100, '0, '0, 1'b0, 31'd3, '0);
    cycle('0, 4'b1000, '0, '0, 1'b0, 31'd4, '0);
    cycle(4'b0001, '0, '0, '0, 1'b0, '0, '0);
    check("tp6_loaded", bus.m_valid, 4'hF);
    #2 rst = 1'b0;
    #1;
    check("tp6_m_valid", bus.m_valid, '0);
    check("tp6_io_in",   bus.io_in,   '0);
    check("tp6_s_ready", bus.s_ready, '0);
    check("tp6_m_data",  bus.m_data,  '0);
    model_reset();
    req = '0; oe = '0; sv = '0; mr = '0; clr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle(pick_strobe(), pick_strobe(), NI'($urandom), NI'($urandom),
            ($urandom_range(0, 31) == 0), NB'($urandom),
            {NB'($urandom), NB'($urandom), NB'($urandom), NB'($urandom)});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rede_io_host.md
# rede_io_host

Host-side I/O adapter for the `proc_fx` network core. It answers the core's one-hot input requests (`req_in`) with data taken from per-port input FIFOs, and captures the core's outputs on the one-hot output strobes (`out_en`) into per-port output registers. Each port has a valid/ready stream interface toward the rest of the system. It is the other end of the `io_in`/`req_in`/`io_out`/`out_en` port protocol and is instantiated next to the `rede` wrapper.

## Interface
- `NUBITS`, 31: data word width (signed, fixed-point).
- `NUIO`, 4: number of input ports and number of output ports.
- `DEPTH`, 2: entries per input FIFO; must be a power of 2 and ≥ 2.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_in`  in  NUIO  one-hot read strobe from the core.
- `io_in`  out  NUBITS  word returned to the core's `io_in`.
- `out_en`  in  NUIO  one-hot write strobe from the core.
- `io_out`  in  NUBITS  word from the core's `io_out`.
- `s_data`  in  NUIO*NUBITS  input stream words; port k occupies bits [k*NUBITS +: NUBITS].
- `s_valid`  in  NUIO  input stream valid, one bit per port.
- `s_ready`  out  NUIO  input stream ready, one bit per port.
- `m_data`  out  NUIO*NUBITS  output stream words, same packing as `s_data`.
- `m_valid`  out  NUIO  output stream valid.
- `m_ready`  in  NUIO  output stream ready.
- `underflow`  out  NUIO  sticky flag per port: the core read an empty port.
- `overflow`  out  NUIO  sticky flag per port: the core overwrote an unconsumed output.
- `stat_clr`  in  1  synchronous clear of both flag vectors.

## Operation
- Input FIFO k: push when `s_valid[k] & s_ready[k]`. `s_ready[k] = !full[k]`. A pop in the same cycle does not make a full FIFO ready.
- `io_in` is combinational. It equals the head of FIFO k when `req_in[k]` = 1 and FIFO k is non-empty. It is 0 when `req_in` = 0 or the selected FIFO is empty.
- Pop FIFO k on the rising edge where `req_in[k]` = 1 and FIFO k is non-empty.
- Read of an empty FIFO: `io_in` = 0, no pointer change, `underflow[k]` is set.
- Push and pop on the same port in the same cycle: occupancy unchanged, order preserved.
- Pointers wrap modulo DEPTH. Occupancy counts from 0 to DEPTH.
- More than one `req_in` bit set is illegal. The lowest set index is served; no other FIFO pops.
- Output port k: on `out_en[k]` the block loads `io_out` into slice k of `m_data` and sets `m_valid[k]` = 1.
- `m_valid[k]` clears on `m_valid[k] & m_ready[k]` when `out_en[k]` is not asserted in the same cycle.
- `out_en[k]` while `m_valid[k] & !m_ready[k]`: the new word overwrites the old one and `overflow[k]` is set.
- `out_en[k]` in the same cycle as a handshake on port k: the new word is loaded, `m_valid[k]` stays 1, no overflow.
- Multiple `out_en` bits set is illegal. Only the lowest index is loaded.
- `stat_clr` clears both flag vectors. A flag event in the same cycle wins, so the flag reads 1 afterward.

## Timing
- Reset values (`rst` low): all FIFOs empty, `s_ready` = 0, `io_in` = 0, `m_data` = 0, `m_valid` = 0, `underflow` = 0, `overflow` = 0.
- `s_ready` goes to all ones in the first cycle after `rst` deasserts.
- Stream input to core: a word pushed at edge t can be returned on `io_in` in cycle t+1, i.e. 1-cycle latency.
- Core read: same-cycle combinational path from `req_in` to `io_in`; the pop takes effect at the next edge.
- Core output to stream: `out_en` sampled at edge t gives `m_valid` and `m_data` in cycle t+1.
- Reset asserted mid-operation discards all FIFO contents and pending outputs immediately, without waiting for a clock edge.

## Configuration
- `REDE_IO_STATUS_EN` defined: `underflow`, `overflow` and `stat_clr` behave as described above.
- Not defined: the status logic is not synthesized. `underflow` and `overflow` are tied to 0 and `stat_clr` is ignored. All data-path behaviour is identical.

## Test plan
- Reset, then push 0x0000123 on port 2. In the next cycle drive `req_in` = 4'b0100 → `io_in` = 0x0000123; port 2 is empty afterward; `underflow` = 0.
- Push 3 words on port 0 with DEPTH = 2 and `req_in` idle → `s_ready[0]` = 0 after 2 words, and the third word is held by the source. Then read twice → the first two words are returned in order and `s_ready[0]` returns to 1.
- `req_in` = 4'b0010 with port 1 empty → `io_in` = 0 and `underflow[1]` = 1. After `stat_clr` for one cycle, `underflow` = 0.
- `out_en` = 4'b1000 with `io_out` = -5 → next cycle `m_valid[3]` = 1 and slice 3 of `m_data` = -5. Holding `m_ready[3]` = 1 for one cycle clears `m_valid[3]`.
- Two `out_en[0]` pulses, with values 7 then 9, while `m_ready[0]` = 0 → slice 0 of `m_data` = 9 and `overflow[0]` = 1. With `REDE_IO_STATUS_EN` undefined, `overflow[0]` = 0.
- Assert `rst` low mid-stream with 1 word queued on each port and `m_valid` = 4'b1111 → all FIFOs empty, `m_valid` = 0 and `io_in` = 0 immediately, without waiting for a clock edge.
